// File: rtl/wisc_pkg.sv
// Shared ISA opcodes and pipeline-control FSM encoding for the WISC core.
package wisc_pkg;

    typedef enum logic [3:0] {
        ADD    = 4'b0000,
        SUB    = 4'b0001,
        XOR    = 4'b0010,
        RED    = 4'b0011,
        PADDSB = 4'b0100,
        SLL    = 4'b0101,
        SRA    = 4'b0110,
        ROR    = 4'b0111,
        LW     = 4'b1000,
        SW     = 4'b1001,
        LLB    = 4'b1010,
        LHB    = 4'b1011,
        B      = 4'b1100,
        BR     = 4'b1101,
        PCS    = 4'b1110,
        HLT    = 4'b1111
    } opcode_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } ctrl_state_t;

    // Cycles spent draining in-flight instructions after HLT reaches ID.
    localparam logic [1:0] DRAIN_LOAD = 2'd3;

endpackage

// File: rtl/src_use_decode.sv
// Decodes which source register fields an ID-stage opcode actually reads.
module src_use_decode
    import wisc_pkg::*;
(
    input  logic [3:0] opcode,
    output logic       rs_use,
    output logic       rt_use
);

    always_comb begin
        rs_use = 1'b0;
        rt_use = 1'b0;
        case (opcode)
            ADD, SUB, XOR, RED, PADDSB, SW: begin
                rs_use = 1'b1;
                rt_use = 1'b1;
            end
            // Shifts and LW carry an immediate in the rt field.
            SLL, SRA, ROR, LW: begin
                rs_use = 1'b1;
            end
            default: begin
                rs_use = 1'b0;
                rt_use = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/halt controller: load-use stalls, branch flushes, memory-busy freeze
// and the HLT drain sequence, with a saturating stall-cycle counter.
module pipeline_ctrl
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  id_opcode,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic [3:0]  ex_rd,
    input  logic        ex_reg_wrt,
    input  logic        ex_mem_to_reg,
    input  logic        br_taken,
    input  logic        mem_busy,
    output logic        pc_en,
    output logic        if_id_en,
    output logic        if_id_flush,
    output logic        id_ex_bubble,
    output logic        halted,
    output logic [15:0] stall_cnt
);

    ctrl_state_t state_reg, state_next;
    logic [1:0]  drain_cnt_reg, drain_cnt_next;
    logic [15:0] stall_cnt_reg;
    logic        rs_use, rt_use;
    logic        load_use;

    src_use_decode u_src_use_decode (
        .opcode (id_opcode),
        .rs_use (rs_use),
        .rt_use (rt_use)
    );

    assign load_use = ex_mem_to_reg && ex_reg_wrt && (ex_rd != 4'd0) &&
                      ((rs_use && (ex_rd == id_rs)) || (rt_use && (ex_rd == id_rt)));

    always_comb begin
        pc_en          = 1'b1;
        if_id_en       = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_bubble   = 1'b0;
        state_next     = state_reg;
        drain_cnt_next = drain_cnt_reg;
        // While reset is held the enables stay in their free-running values.
        if (rst_n) begin
            if (state_reg == HALTED) begin
                pc_en        = 1'b0;
                if_id_en     = 1'b0;
                id_ex_bubble = 1'b1;
            end else if (mem_busy) begin
                pc_en    = 1'b0;
                if_id_en = 1'b0;
            end else begin
                case (state_reg)
                    RUN: begin
                        if (br_taken) begin
                            if_id_flush  = 1'b1;
                            id_ex_bubble = 1'b1;
                        end else if (load_use) begin
                            pc_en        = 1'b0;
                            if_id_en     = 1'b0;
                            id_ex_bubble = 1'b1;
                        end else if (id_opcode == HLT) begin
                            pc_en          = 1'b0;
                            if_id_en       = 1'b0;
                            id_ex_bubble   = 1'b1;
                            drain_cnt_next = DRAIN_LOAD;
                            state_next     = DRAIN;
                        end
                    end
                    DRAIN: begin
                        // A taken branch means the HLT was fetched down the wrong path.
                        if (br_taken) begin
                            if_id_flush    = 1'b1;
                            id_ex_bubble   = 1'b1;
                            drain_cnt_next = 2'd0;
                            state_next     = RUN;
                        end else begin
                            pc_en          = 1'b0;
                            if_id_en       = 1'b0;
                            id_ex_bubble   = 1'b1;
                            drain_cnt_next = drain_cnt_reg - 2'd1;
                            if (drain_cnt_reg == 2'd1) begin
                                state_next = HALTED;
                            end
                        end
                    end
                    default: begin
                        state_next = RUN;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= RUN;
            drain_cnt_reg <= 2'd0;
            stall_cnt_reg <= 16'd0;
        end else begin
            state_reg     <= state_next;
            drain_cnt_reg <= drain_cnt_next;
            if (!pc_en && (state_reg != HALTED) && (stall_cnt_reg != 16'hFFFF)) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign halted    = (state_reg == HALTED);
    assign stall_cnt = stall_cnt_reg;

endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have port clk  in  1  single rising-edge clock for all state.
REQ-002 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have port id_opcode  in  4  opcode of the instruction in ID.
REQ-004 SHALL have ports id_rs, id_rt  in  4 each  source register indices in ID.
REQ-005 SHALL have port ex_rd  in  4  destination index of the instruction in EX.
REQ-006 SHALL have ports ex_reg_wrt, ex_mem_to_reg  in  1 each  EX-stage write enable and load flag.
REQ-007 SHALL have port br_taken  in  1  branch/call/ret resolved taken in EX.
REQ-008 SHALL have port mem_busy  in  1  data memory not ready this cycle.
REQ-009 SHALL have ports pc_en, if_id_en  out  1 each  PC and IF/ID register load enables.
REQ-010 SHALL have ports if_id_flush, id_ex_bubble  out  1 each  squash IF/ID; insert NOP into ID/EX.
REQ-011 SHALL have port halted  out  1  sticky processor-halted indication.
REQ-012 SHALL have port stall_cnt  out  16  count of cycles with pc_en low.

Function
REQ-013 SHALL implement states RUN, DRAIN, HALTED.
REQ-014 SHALL define rs-use for opcodes 0000-0111, 1000, 1001; rt-use for 0000-0100 and 1001.
REQ-015 SHALL detect load-use when ex_mem_to_reg & ex_reg_wrt & ex_rd!=0 & ex_rd matches a used source of id_opcode.
REQ-016 SHALL, on mem_busy=1, drive pc_en=0, if_id_en=0, flush=0, bubble=0 and hold state and drain counter; this overrides all other rules.
REQ-017 SHALL, in RUN with br_taken=1, drive if_id_flush=1, id_ex_bubble=1, pc_en=1, if_id_en=1 (one-cycle, no state change).
REQ-018 SHALL, in RUN with load-use and no br_taken, drive pc_en=0, if_id_en=0, id_ex_bubble=1 for exactly that cycle; stall repeats only while condition persists.
REQ-019 SHALL, in RUN with id_opcode=1111 and no br_taken and no load-use, drive pc_en=0, if_id_en=0, id_ex_bubble=1, load 2-bit drain counter with 3, enter DRAIN.
REQ-020 SHALL, in DRAIN, hold pc_en=0, if_id_en=0, id_ex_bubble=1, decrement counter per non-busy cycle, enter HALTED when counter reaches 0 after decrement (3 DRAIN cycles).
REQ-021 SHALL, in DRAIN with br_taken=1, abort halt: flush=1, bubble=1, pc_en=1, if_id_en=1, return to RUN (hlt was in branch shadow).
REQ-022 SHALL, in HALTED, drive halted=1, pc_en=0, if_id_en=0, id_ex_bubble=1, ignore all inputs until reset.
REQ-023 SHALL otherwise drive pc_en=1, if_id_en=1, flush=0, bubble=0.
REQ-024 SHALL increment stall_cnt on each cycle with pc_en=0 outside HALTED, saturating at 16'hFFFF.
REQ-025 SHALL generate all enables combinationally from state and inputs (zero latency); state, counter, stall_cnt registered.

Reset
REQ-026 SHALL on rst_n=0 immediately set state=RUN, drain counter=0, stall_cnt=0, halted=0.
REQ-027 SHALL, during reset, present pc_en=1, if_id_en=1, flush=0, bubble=0 regardless of mid-operation state.
REQ-028 SHALL release from reset on the first rising clk after rst_n=1 with no spurious stall.

Structure
REQ-029 SHALL take opcode constants (ADD..HLT, 4'b0000..4'b1111) and state encoding from shared package wisc_pkg.
REQ-030 SHALL place the rs/rt use decode in sub-module src_use_decode (combinational, opcode in, two flags out).

Verification
REQ-031 SHALL cover: lw r3 in EX, add using r3 in ID -> one cycle pc_en=0, bubble=1, stall_cnt 0->1.
REQ-032 SHALL cover: lw r0 in EX, add using r0 in ID -> no stall; sll using rt=r3 after lw r3 -> no stall.
REQ-033 SHALL cover: br_taken=1 with load-use same cycle -> flush=1, bubble=1, pc_en=1, no stall.
REQ-034 SHALL cover: hlt in ID -> 3 DRAIN cycles then halted=1 on 4th edge; stall_cnt=4 at halt; br_taken in HALTED ignored.
REQ-035 SHALL cover: hlt then br_taken on 2nd DRAIN cycle -> state RUN, halted=0, pc_en=1 next cycle.
REQ-036 SHALL cover: mem_busy=1 for 2 cycles mid-DRAIN -> counter frozen, HALTED reached 2 cycles later; rst_n pulse in HALTED -> halted=0, stall_cnt=0 asynchronously.
